// File: rtl/op_decode_pkg.sv
// ============================================================================
// Module      : op_decode_pkg
// Description : Shared constants, decoded-record type and opcode classifier
//               for the op_decode_q instruction decode queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package op_decode_pkg;

    // Datapath classes
    localparam logic [2:0] DP_NONE    = 3'd0;
    localparam logic [2:0] DP_ARITH   = 3'd1;
    localparam logic [2:0] DP_LOGICAL = 3'd2;
    localparam logic [2:0] DP_MEMORY  = 3'd3;
    localparam logic [2:0] DP_COMPARE = 3'd4;
    localparam logic [2:0] DP_JUMP    = 3'd5;
    localparam logic [2:0] DP_BRANCH  = 3'd6;

    localparam int REC_TYPE_W = 4;

    localparam logic [REC_TYPE_W-1:0] TYPE_0 = 4'd0;
    localparam logic [REC_TYPE_W-1:0] TYPE_1 = 4'd1;
    localparam logic [REC_TYPE_W-1:0] TYPE_2 = 4'd2;
    localparam logic [REC_TYPE_W-1:0] TYPE_3 = 4'd3;
    localparam logic [REC_TYPE_W-1:0] TYPE_4 = 4'd4;
    localparam logic [REC_TYPE_W-1:0] TYPE_5 = 4'd5;
    localparam logic [REC_TYPE_W-1:0] TYPE_6 = 4'd6;
    localparam logic [REC_TYPE_W-1:0] TYPE_7 = 4'd7;
    localparam logic [REC_TYPE_W-1:0] TYPE_8 = 4'd8;
    localparam logic [REC_TYPE_W-1:0] TYPE_9 = 4'd9;

    // Opcode / funct values that select specific type codes
    localparam logic [5:0] OP_LOGIC_T2  = 6'd13;
    localparam logic [5:0] OP_LOGIC_T4  = 6'd15;
    localparam logic [5:0] OP_LOGIC_T5  = 6'd10;
    localparam logic [5:0] OP_BRANCH_T7 = 6'd20;
    localparam logic [5:0] OP_BRANCH_T8 = 6'd21;
    localparam logic [5:0] OP_BRANCH_T9 = 6'd23;
    localparam logic [5:0] FN_ARITH_T1A = 6'd34;
    localparam logic [5:0] FN_ARITH_T1B = 6'd35;
    localparam logic [5:0] FN_LOGIC_T2  = 6'd36;
    localparam logic [5:0] OP_MEM_A     = 6'd40;
    localparam logic [5:0] OP_MEM_B     = 6'd41;
    localparam logic [5:0] OP_CMP_A     = 6'd32;
    localparam logic [5:0] OP_CMP_B     = 6'd33;

    typedef struct packed {
        logic [2:0]            dp;
        logic [REC_TYPE_W-1:0] typ;
        logic                  illegal;
        logic [4:0]            rs;
        logic [4:0]            rt;
        logic [4:0]            rd;
        logic [15:0]           imm;
    } dec_rec_t;

    function automatic dec_rec_t op_classify(input logic [31:0] ins);
        dec_rec_t   r;
        logic [5:0] op;
        logic [5:0] fn;
        op        = ins[31:26];
        fn        = ins[5:0];
        r         = '0;
        r.rs      = ins[25:21];
        r.rt      = ins[20:16];
        r.rd      = ins[15:11];
        r.imm     = ins[15:0];
        if (op < 6'd3) begin
            r.dp  = DP_ARITH;
            r.typ = (fn == FN_ARITH_T1A || fn == FN_ARITH_T1B) ? TYPE_1 : TYPE_0;
        end else if (op >= 6'd8 && op < 6'd16) begin
            r.dp = DP_LOGICAL;
            if (fn == FN_LOGIC_T2 || op == OP_LOGIC_T2) r.typ = TYPE_2;
            else if (op == OP_LOGIC_T4)                  r.typ = TYPE_4;
            else if (op == OP_LOGIC_T5)                  r.typ = TYPE_5;
            else                                         r.typ = TYPE_3;
        end else if (op == OP_MEM_A || op == OP_MEM_B) begin
            r.dp  = DP_MEMORY;
            r.typ = TYPE_0;
        end else if (op == OP_CMP_A || op == OP_CMP_B) begin
            r.dp  = DP_COMPARE;
            r.typ = TYPE_6;
        end else if (op > 6'd50) begin
            r.dp  = DP_JUMP;
            r.typ = TYPE_0;
        end else begin
            // Everything left lands in the branch class; unknown ones are flagged
            r.dp = DP_BRANCH;
            case (op)
                OP_BRANCH_T7: r.typ = TYPE_7;
                OP_BRANCH_T8: r.typ = TYPE_8;
                OP_BRANCH_T9: r.typ = TYPE_9;
                default: begin
                    r.typ     = TYPE_0;
                    r.illegal = 1'b1;
                end
            endcase
        end
        return r;
    endfunction

endpackage

`default_nettype wire

// File: rtl/decode_fifo.sv
// ============================================================================
// Module      : decode_fifo
// Description : Generic synchronous first-word-fall-through queue with
//               occupancy count and flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module decode_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_flush,
    input  logic                   i_valid,
    output logic                   o_ready,
    input  logic [WIDTH-1:0]       i_data,
    output logic                   o_valid,
    input  logic                   i_ready,
    output logic [WIDTH-1:0]       o_data,
    output logic [$clog2(DEPTH):0] o_count
);

    localparam int              c_AW   = $clog2(DEPTH);
    localparam logic [c_AW:0]   c_FULL = (c_AW+1)'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wr_ptr;
    logic [c_AW-1:0]  r_rd_ptr;
    logic [c_AW:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_ready = (r_count != c_FULL);
    assign o_valid = (r_count != '0);
    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign w_push  = i_valid && o_ready;
    assign w_pop   = o_valid && i_ready;

    always_ff @(posedge clk) begin
        if (w_push && !i_flush && !rst) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two
    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + (c_AW+1)'(1);
                2'b01:   r_count <= r_count - (c_AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: rtl/op_decode_q.sv
// ============================================================================
// Module      : op_decode_q
// Description : Instruction decoder feeding a DEPTH-entry FWFT issue queue.
//               Optional per-class statistics with OP_DECODE_STATS_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module op_decode_q
    import op_decode_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4,
    parameter int TYPE_W = 4,
    parameter int STAT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [DATA_W-1:0]      in_ins,
    input  logic [DATA_W-1:0]      in_pc,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2:0]             out_data_path,
    output logic [TYPE_W-1:0]      out_type,
    output logic                   out_illegal,
    output logic [4:0]             out_rs,
    output logic [4:0]             out_rt,
    output logic [4:0]             out_rd,
    output logic [DATA_W-1:0]      out_imm,
    output logic [DATA_W-1:0]      out_pc,
    output logic [$clog2(DEPTH):0] out_count
`ifdef OP_DECODE_STATS_EN
    ,
    output logic [6*STAT_W-1:0]    stat_cnt,
    output logic [STAT_W-1:0]      stat_illegal
`endif
);

    typedef struct packed {
        dec_rec_t          rec;
        logic [DATA_W-1:0] pc;
    } entry_t;

    if (DATA_W < 32 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 ||
        TYPE_W < REC_TYPE_W || STAT_W < 1) begin : g_param_check
        $error("op_decode_q: illegal parameter combination");
    end

    dec_rec_t w_dec;
    entry_t   w_in_entry;
    entry_t   w_head;
    logic     w_head_valid;
    logic     w_in_ready;
    logic     w_unused_ins;

    assign w_dec        = op_classify(in_ins[31:0]);
    assign w_in_entry   = '{rec: w_dec, pc: in_pc};
    assign w_unused_ins = ^in_ins;

    decode_fifo #(
        .WIDTH ($bits(entry_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_flush (flush),
        .i_valid (in_valid),
        .o_ready (w_in_ready),
        .i_data  (w_in_entry),
        .o_valid (w_head_valid),
        .i_ready (out_ready),
        .o_data  (w_head),
        .o_count (out_count)
    );

    assign in_ready  = w_in_ready;
    assign out_valid = w_head_valid;

    // Record fields are forced to zero whenever the queue is empty
    always_comb begin
        out_data_path = '0;
        out_type      = '0;
        out_illegal   = 1'b0;
        out_rs        = '0;
        out_rt        = '0;
        out_rd        = '0;
        out_imm       = '0;
        out_pc        = '0;
        if (w_head_valid) begin
            out_data_path = w_head.rec.dp;
            out_type      = TYPE_W'(w_head.rec.typ);
            out_illegal   = w_head.rec.illegal;
            out_rs        = w_head.rec.rs;
            out_rt        = w_head.rec.rt;
            out_rd        = w_head.rec.rd;
            out_imm       = {{(DATA_W-16){w_head.rec.imm[15]}}, w_head.rec.imm};
            out_pc        = w_head.pc;
        end
    end

`ifdef OP_DECODE_STATS_EN
    logic             w_push;
    logic [STAT_W-1:0] r_illegal_cnt;

    assign w_push = in_valid && w_in_ready && !flush;

    for (genvar k = 1; k <= 6; k++) begin : g_stat
        logic [STAT_W-1:0] r_cnt;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_cnt <= '0;
            end else if (w_push && w_dec.dp == 3'(k) && r_cnt != '1) begin
                r_cnt <= r_cnt + STAT_W'(1);
            end
        end
        assign stat_cnt[k*STAT_W-1 -: STAT_W] = r_cnt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_illegal_cnt <= '0;
        end else if (w_push && w_dec.illegal && r_illegal_cnt != '1) begin
            r_illegal_cnt <= r_illegal_cnt + STAT_W'(1);
        end
    end

    assign stat_illegal = r_illegal_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_op_decode_q.sv
// ============================================================================
// Module      : tb_op_decode_q
// Description : Self-checking bench for op_decode_q (vector table plus
//               backpressure, flush and reset sequences).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_op_decode_q;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int TYPE_W = 4;
    localparam int STAT_W = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_ins;
    logic [DATA_W-1:0] in_pc;
    logic              out_valid;
    logic              out_ready;
    logic [2:0]        out_data_path;
    logic [TYPE_W-1:0] out_type;
    logic              out_illegal;
    logic [4:0]        out_rs;
    logic [4:0]        out_rt;
    logic [4:0]        out_rd;
    logic [DATA_W-1:0] out_imm;
    logic [DATA_W-1:0] out_pc;
    logic [2:0]        out_count;
`ifdef OP_DECODE_STATS_EN
    logic [6*STAT_W-1:0] stat_cnt;
    logic [STAT_W-1:0]   stat_illegal;
`endif

    op_decode_q #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .TYPE_W (TYPE_W),
        .STAT_W (STAT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .flush         (flush),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_ins        (in_ins),
        .in_pc         (in_pc),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data_path (out_data_path),
        .out_type      (out_type),
        .out_illegal   (out_illegal),
        .out_rs        (out_rs),
        .out_rt        (out_rt),
        .out_rd        (out_rd),
        .out_imm       (out_imm),
        .out_pc        (out_pc),
        .out_count     (out_count)
`ifdef OP_DECODE_STATS_EN
        ,
        .stat_cnt      (stat_cnt),
        .stat_illegal  (stat_illegal)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] ins;
        logic [2:0]  dp;
        logic [3:0]  typ;
        logic        ill;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [31:0] imm;
    } vec_t;

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_empty(input string nm);
        chk({nm, "_in_ready"},  in_ready, 1);
        chk({nm, "_out_valid"}, out_valid, 0);
        chk({nm, "_count"},     out_count, 0);
        chk({nm, "_fields"},
            {out_data_path, out_type, out_illegal, out_rs, out_rt, out_rd} , 0);
        chk({nm, "_imm"}, out_imm, 0);
        chk({nm, "_pc"},  out_pc, 0);
    endtask

    // Push n instructions (ins0 | i<<11), pc0+i, with current out_ready
    task automatic push_n(input int n, input logic [31:0] ins0, input logic [31:0] pc0);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ins   = ins0 | (32'(i) << 11);
            in_pc    = pc0 + 32'(i);
            @(posedge clk);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //            ins           dp    typ   ill   rs    rt    rd     imm
        vecs[0]  = '{32'h00430820, 3'd1, 4'd0, 1'b0, 5'd2, 5'd3, 5'd1,  32'h00000820};
        vecs[1]  = '{32'h00430822, 3'd1, 4'd1, 1'b0, 5'd2, 5'd3, 5'd1,  32'h00000822};
        vecs[2]  = '{32'h3C011234, 3'd2, 4'd4, 1'b0, 5'd0, 5'd1, 5'd2,  32'h00001234};
        vecs[3]  = '{32'h5000FFFF, 3'd6, 4'd7, 1'b0, 5'd0, 5'd0, 5'd31, 32'hFFFFFFFF};
        vecs[4]  = '{32'h0C000000, 3'd6, 4'd0, 1'b1, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[5]  = '{32'h34000000, 3'd2, 4'd2, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[6]  = '{32'h28000000, 3'd2, 4'd5, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[7]  = '{32'h20000024, 3'd2, 4'd2, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000024};
        vecs[8]  = '{32'h24000000, 3'd2, 4'd3, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[9]  = '{32'hA0000000, 3'd3, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[10] = '{32'hA4000000, 3'd3, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[11] = '{32'h80000000, 3'd4, 4'd6, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[12] = '{32'h84000000, 3'd4, 4'd6, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[13] = '{32'hCC000000, 3'd5, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[14] = '{32'hC8000000, 3'd6, 4'd0, 1'b1, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[15] = '{32'hFC000000, 3'd5, 4'd0, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[16] = '{32'h54000000, 3'd6, 4'd8, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[17] = '{32'h5C000000, 3'd6, 4'd9, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[18] = '{32'h58000000, 3'd6, 4'd0, 1'b1, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[19] = '{32'h08000023, 3'd1, 4'd1, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000023};
        vecs[20] = '{32'h40000000, 3'd6, 4'd0, 1'b1, 5'd0, 5'd0, 5'd0,  32'h00000000};
        vecs[21] = '{32'h3C000024, 3'd2, 4'd2, 1'b0, 5'd0, 5'd0, 5'd0,  32'h00000024};
        vecs[22] = '{32'h00008000, 3'd1, 4'd0, 1'b0, 5'd0, 5'd0, 5'd16, 32'hFFFF8000};

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_ins    = '0;
        in_pc     = '0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_empty("reset");
        @(negedge clk);
        rst = 1'b0;

`ifdef OP_DECODE_STATS_EN
        // Five arithmetic pushes saturate a 2-bit class counter at 3
        out_ready = 1'b1;
        push_n(5, 32'h00430820, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("stat_arith_sat", stat_cnt[1:0], 2'd3);
        chk("stat_logical",   stat_cnt[3:2], 2'd0);
        chk("stat_illegal0",  stat_illegal, 2'd0);
        chk("stat_drained",   out_count, 0);
`endif

        // Table: push one vector, check the head, let it pop
        out_ready = 1'b1;
        for (int v = 0; v < NVEC; v++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_ins   = vecs[v].ins;
            in_pc    = 32'h1000 + 32'(v * 4);
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            chk($sformatf("v%0d_valid", v), out_valid, 1);
            chk($sformatf("v%0d_count", v), out_count, 1);
            chk($sformatf("v%0d_dp", v), out_data_path, vecs[v].dp);
            chk($sformatf("v%0d_type", v), out_type, vecs[v].typ);
            chk($sformatf("v%0d_illegal", v), out_illegal, vecs[v].ill);
            chk($sformatf("v%0d_regs", v), {out_rs, out_rt, out_rd},
                {vecs[v].rs, vecs[v].rt, vecs[v].rd});
            chk($sformatf("v%0d_imm", v), out_imm, vecs[v].imm);
            chk($sformatf("v%0d_pc", v), out_pc, 32'h1000 + 32'(v * 4));
            @(posedge clk);
        end
        #1;
        chk("table_drained", out_count, 0);

        // Backpressure: 5 offered into a 4-deep queue with consumer stalled
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            in_valid = 1'b1;
            in_ins   = 32'(i) << 11;
            in_pc    = 32'h100 + 32'(i);
            @(posedge clk);
            #1;
            chk($sformatf("bp%0d_count", i), out_count, (i < 4) ? i + 1 : 4);
            chk($sformatf("bp%0d_in_ready", i), in_ready, (i < 3) ? 1 : 0);
            @(negedge clk);
        end
        chk("bp_head_pc", out_pc, 32'h100);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_pop_count", out_count, 3);
        chk("bp_pop_ready", in_ready, 1);
        chk("bp_pop_head",  out_pc, 32'h101);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        chk("bp_5th_count", out_count, 3);
        for (int j = 2; j <= 4; j++) begin
            chk($sformatf("bp_drain%0d_pc", j), out_pc, 32'h100 + 32'(j));
            chk($sformatf("bp_drain%0d_rd", j), out_rd, j);
            @(posedge clk);
            #1;
        end
        chk("bp_empty_count", out_count, 0);
        chk("bp_empty_valid", out_valid, 0);

        // Flush a full queue while offering a new instruction
        @(negedge clk);
        out_ready = 1'b0;
        push_n(4, 32'h00430820, 32'h200);
        chk("fl_full_count", out_count, 4);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_ins   = 32'h3C011234;
        in_pc    = 32'h300;
        @(posedge clk);
        #1;
        check_empty("flush");
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        chk("fl_lost_count", out_count, 0);

        // Reset mid-stream with 3 entries queued
        push_n(3, 32'h00430820, 32'h400);
        chk("rst_pre_count", out_count, 3);
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_ins    = 32'h00430820;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check_empty("rst_mid");
`ifdef OP_DECODE_STATS_EN
        chk("rst_stat_cnt", stat_cnt, 0);
        chk("rst_stat_ill", stat_illegal, 0);
`endif
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        @(posedge clk);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
